// File: rtl/alu_chk_pkg.sv
// ---------------------------------------------------------------------------
// alu_chk_pkg
// Shared definitions for the dual-ALU lockstep checker:
//   - DW_DEFAULT : default ALU result width per lane
//   - state_t    : checker FSM encodings (also the state_o encoding)
//   - ALU_SEL_*  : op-select codes shared by both ALU lanes
// ---------------------------------------------------------------------------
package alu_chk_pkg;

   localparam int DW_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_CHECK   = 2'b01,
      ST_SUSPECT = 2'b10,
      ST_FAULT   = 2'b11
   } state_t;

   localparam logic [1:0] ALU_SEL_ADD = 2'b00;
   localparam logic [1:0] ALU_SEL_SUB = 2'b01;
   localparam logic [1:0] ALU_SEL_AND = 2'b10;
   localparam logic [1:0] ALU_SEL_OR  = 2'b11;

endpackage : alu_chk_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that holds at its all-ones value instead of wrapping.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (q -> 0)
//   clr : synchronous clear, same effect as rst
//   inc : count one event this cycle
//   q   : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] Q_MAX = {W{1'b1}};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != Q_MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/alu_lockstep_checker.sv
// ---------------------------------------------------------------------------
// alu_lockstep_checker
// Compares the two lanes of the dual 8-bit ALU every valid cycle. Counts
// compares and mismatches (saturating), captures the first mismatching pair,
// and enters a sticky FAULT after MISMATCH_LIMIT consecutive mismatches.
// Pipeline: stage 1 registers the lanes, stage 2 compares and updates
// mismatch_o / counters / capture / FSM (in_valid -> result = 2 cycles).
// Ports:
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   enable_i                : 0 = ignore in_valid
//   clear_i                 : synchronous clear of all status and the FSM
//   in_valid, alu_sel_i     : lane results valid, shared op select
//   alu_out1_i, carry1_i    : lane-1 result and carry
//   alu_out2_i, carry2_i    : lane-2 result and carry
//   mismatch_o              : 1-cycle pulse per mismatching compare
//   fault_o, state_o        : sticky fault, FSM state
//   cmp_count_o, err_count_o: saturating compare / mismatch counts
//   first_err_o, first_err_sel_o, first_err_vld_o : first mismatch capture
// ---------------------------------------------------------------------------
module alu_lockstep_checker
   import alu_chk_pkg::*;
#(
   parameter int DW             = DW_DEFAULT,
   parameter int CW             = 16,
   parameter int MISMATCH_LIMIT = 3
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            enable_i,
   input  logic            clear_i,
   input  logic            in_valid,
   input  logic [1:0]      alu_sel_i,
   input  logic [DW-1:0]   alu_out1_i,
   input  logic            carry1_i,
   input  logic [DW-1:0]   alu_out2_i,
   input  logic            carry2_i,
   output logic            mismatch_o,
   output logic            fault_o,
   output logic [1:0]      state_o,
   output logic [CW-1:0]   cmp_count_o,
   output logic [CW-1:0]   err_count_o,
   output logic [2*DW+1:0] first_err_o,
   output logic [1:0]      first_err_sel_o,
   output logic            first_err_vld_o
);

   localparam logic [3:0] LIMIT = 4'(MISMATCH_LIMIT);

   // reset and clear act identically on everything below
   logic kill;
   assign kill = wb_rst_i | clear_i;

   // ---------------- stage 1: lane capture ----------------
   logic          s1_vld;
   logic [1:0]    s1_sel;
   logic [DW-1:0] s1_out1, s1_out2;
   logic          s1_c1, s1_c2;

   always_ff @(posedge wb_clk_i) begin
      if (kill) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= enable_i & in_valid;
      end
   end

   // NOTE: the stage-1 data registers carry no reset; they are only ever
   // consumed when s1_vld is set, which is itself reset.
   always_ff @(posedge wb_clk_i) begin
      if (enable_i && in_valid) begin
         s1_sel  <= alu_sel_i;
         s1_out1 <= alu_out1_i;
         s1_c1   <= carry1_i;
         s1_out2 <= alu_out2_i;
         s1_c2   <= carry2_i;
      end
   end

   // ---------------- stage 2: compare ----------------
   logic mis;
   assign mis = s1_vld & ({s1_out1, s1_c1} != {s1_out2, s1_c2});

   always_ff @(posedge wb_clk_i) begin
      if (kill) begin
         mismatch_o <= 1'b0;
      end else begin
         mismatch_o <= mis;
      end
   end

   // first-mismatch capture; later mismatches never overwrite it
   always_ff @(posedge wb_clk_i) begin
      if (kill) begin
         first_err_o     <= '0;
         first_err_sel_o <= '0;
         first_err_vld_o <= 1'b0;
      end else if (mis && !first_err_vld_o) begin
         first_err_o     <= {s1_out1, s1_c1, s1_out2, s1_c2};
         first_err_sel_o <= s1_sel;
         first_err_vld_o <= 1'b1;
      end
   end

   sat_counter #(.W(CW)) u_cmp_count (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .clr (clear_i),
      .inc (s1_vld),
      .q   (cmp_count_o)
   );

   sat_counter #(.W(CW)) u_err_count (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .clr (clear_i),
      .inc (mis),
      .q   (err_count_o)
   );

   // ---------------- checker FSM ----------------
   state_t     state, state_nxt;
   logic [3:0] consec, consec_nxt;
   logic [3:0] consec_inc;

   assign consec_inc = consec + 4'd1;

   always_ff @(posedge wb_clk_i) begin
      if (kill) begin
         state  <= ST_IDLE;
         consec <= '0;
      end else begin
         state  <= state_nxt;
         consec <= consec_nxt;
      end
   end

   // NOTE: every variable driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      consec_nxt = consec;
      if (s1_vld) begin
         unique case (state)
            // IDLE still evaluates the compare that wakes it up
            ST_IDLE, ST_CHECK: begin
               if (mis) begin
                  consec_nxt = 4'd1;
                  state_nxt  = (LIMIT == 4'd1) ? ST_FAULT : ST_SUSPECT;
               end else begin
                  consec_nxt = '0;
                  state_nxt  = ST_CHECK;
               end
            end
            ST_SUSPECT: begin
               if (mis) begin
                  consec_nxt = consec_inc;
                  if (consec_inc >= LIMIT) begin
                     state_nxt = ST_FAULT;
                  end
               end else begin
                  consec_nxt = '0;
                  state_nxt  = ST_CHECK;
               end
            end
            ST_FAULT: begin
               state_nxt = ST_FAULT;  // absorbing until reset/clear
            end
            default: begin
               state_nxt  = ST_IDLE;
               consec_nxt = '0;
            end
         endcase
      end
   end

   assign state_o = state;
   assign fault_o = (state == ST_FAULT);

endmodule : alu_lockstep_checker

// File: tb/tb_alu_lockstep_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_lockstep_checker
// Directed bench for alu_lockstep_checker. Two instances share the stimulus:
// dut (CW=16) and dut_sat (CW=4, used for saturation). Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_lockstep_checker;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        enable_i = 1'b1;
   logic        clear_i  = 1'b0;
   logic        in_valid = 1'b0;
   logic [1:0]  alu_sel_i  = 2'b00;
   logic [7:0]  alu_out1_i = 8'h00;
   logic        carry1_i   = 1'b0;
   logic [7:0]  alu_out2_i = 8'h00;
   logic        carry2_i   = 1'b0;

   logic        mismatch_o, fault_o, first_err_vld_o;
   logic [1:0]  state_o, first_err_sel_o;
   logic [15:0] cmp_count_o, err_count_o;
   logic [17:0] first_err_o;

   logic        sat_mismatch, sat_fault, sat_first_vld;
   logic [1:0]  sat_state, sat_first_sel;
   logic [3:0]  sat_cmp_count, sat_err_count;
   logic [17:0] sat_first_err;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   alu_lockstep_checker #(.DW(8), .CW(16), .MISMATCH_LIMIT(3)) dut (
      .wb_clk_i        (wb_clk_i),
      .wb_rst_i        (wb_rst_i),
      .enable_i        (enable_i),
      .clear_i         (clear_i),
      .in_valid        (in_valid),
      .alu_sel_i       (alu_sel_i),
      .alu_out1_i      (alu_out1_i),
      .carry1_i        (carry1_i),
      .alu_out2_i      (alu_out2_i),
      .carry2_i        (carry2_i),
      .mismatch_o      (mismatch_o),
      .fault_o         (fault_o),
      .state_o         (state_o),
      .cmp_count_o     (cmp_count_o),
      .err_count_o     (err_count_o),
      .first_err_o     (first_err_o),
      .first_err_sel_o (first_err_sel_o),
      .first_err_vld_o (first_err_vld_o)
   );

   alu_lockstep_checker #(.DW(8), .CW(4), .MISMATCH_LIMIT(3)) dut_sat (
      .wb_clk_i        (wb_clk_i),
      .wb_rst_i        (wb_rst_i),
      .enable_i        (enable_i),
      .clear_i         (clear_i),
      .in_valid        (in_valid),
      .alu_sel_i       (alu_sel_i),
      .alu_out1_i      (alu_out1_i),
      .carry1_i        (carry1_i),
      .alu_out2_i      (alu_out2_i),
      .carry2_i        (carry2_i),
      .mismatch_o      (sat_mismatch),
      .fault_o         (sat_fault),
      .state_o         (sat_state),
      .cmp_count_o     (sat_cmp_count),
      .err_count_o     (sat_err_count),
      .first_err_o     (sat_first_err),
      .first_err_sel_o (sat_first_sel),
      .first_err_vld_o (sat_first_vld)
   );

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] sel,
                        input logic [7:0] o1, input logic c1,
                        input logic [7:0] o2, input logic c2);
      in_valid   = v;
      alu_sel_i  = sel;
      alu_out1_i = o1;
      carry1_i   = c1;
      alu_out2_i = o2;
      carry2_i   = c2;
   endtask

   task automatic do_clear();
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      repeat (3) tick();
      tests_run++;
      if ({mismatch_o, fault_o, state_o, cmp_count_o, err_count_o, first_err_o,
           first_err_sel_o, first_err_vld_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: mis=%b flt=%b st=%b cmp=%0d err=%0d fe=%h sel=%b vld=%b, all must be 0",
                  mismatch_o, fault_o, state_o, cmp_count_o, err_count_o, first_err_o,
                  first_err_sel_o, first_err_vld_o);
      end
      wb_rst_i = 1'b0;
      tick();
      tests_run++;
      if (state_o !== 2'b00) begin
         tests_failed++; $display("FAIL reset_idle: state=%b expected 00", state_o);
      end
   endtask

   task automatic test_match_stream();
      int pulses = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 2'b00, 8'h02, 1'b1, 8'h02, 1'b1);
         tick();
         if (mismatch_o !== 1'b0) pulses++;
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      repeat (2) begin
         tick();
         if (mismatch_o !== 1'b0) pulses++;
      end
      tests_run++;
      if (pulses != 0) begin
         tests_failed++; $display("FAIL match_no_pulse: got %0d mismatch pulses, expected 0", pulses);
      end
      tests_run++;
      if (cmp_count_o !== 16'd10) begin
         tests_failed++; $display("FAIL match_cmp: got %0d expected 10", cmp_count_o);
      end
      tests_run++;
      if (err_count_o !== 16'd0) begin
         tests_failed++; $display("FAIL match_err: got %0d expected 0", err_count_o);
      end
      tests_run++;
      if (state_o !== 2'b01) begin
         tests_failed++; $display("FAIL match_state: got %b expected 01", state_o);
      end
   endtask

   task automatic test_single_glitch();
      do_clear();
      drive(1'b1, 2'b01, 8'h02, 1'b1, 8'h02, 1'b1);   // match
      tick();
      drive(1'b1, 2'b01, 8'h02, 1'b1, 8'h03, 1'b1);   // glitch
      tick();                                          // match compared
      tests_run++;
      if (mismatch_o !== 1'b0 || state_o !== 2'b01) begin
         tests_failed++; $display("FAIL glitch_pre: mis=%b state=%b expected 0/01", mismatch_o, state_o);
      end
      drive(1'b1, 2'b01, 8'h02, 1'b1, 8'h02, 1'b1);   // match
      tick();                                          // glitch compared
      tests_run++;
      if (mismatch_o !== 1'b1 || state_o !== 2'b10) begin
         tests_failed++; $display("FAIL glitch_pulse: mis=%b state=%b expected 1/10", mismatch_o, state_o);
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();                                          // match compared
      tests_run++;
      if (mismatch_o !== 1'b0 || state_o !== 2'b01) begin
         tests_failed++; $display("FAIL glitch_recover: mis=%b state=%b expected 0/01", mismatch_o, state_o);
      end
      tests_run++;
      if (first_err_o !== {8'h02, 1'b1, 8'h03, 1'b1} || first_err_vld_o !== 1'b1
          || first_err_sel_o !== 2'b01) begin
         tests_failed++; $display("FAIL glitch_capture: fe=%h vld=%b sel=%b expected %h/1/01",
                                  first_err_o, first_err_vld_o, first_err_sel_o,
                                  {8'h02, 1'b1, 8'h03, 1'b1});
      end
      tests_run++;
      if (cmp_count_o !== 16'd3 || err_count_o !== 16'd1) begin
         tests_failed++; $display("FAIL glitch_counts: cmp=%0d err=%0d expected 3/1", cmp_count_o, err_count_o);
      end
   endtask

   task automatic test_fault();
      do_clear();
      drive(1'b1, 2'b10, 8'h10, 1'b0, 8'h11, 1'b0);   // m1
      tick();
      drive(1'b1, 2'b10, 8'h10, 1'b0, 8'h11, 1'b0);   // m2
      tick();                                          // m1 compared
      drive(1'b1, 2'b10, 8'h10, 1'b0, 8'h11, 1'b0);   // m3
      tick();                                          // m2 compared
      tests_run++;
      if (state_o !== 2'b10 || fault_o !== 1'b0) begin
         tests_failed++; $display("FAIL fault_suspect: state=%b fault=%b expected 10/0", state_o, fault_o);
      end
      drive(1'b1, 2'b11, 8'h55, 1'b1, 8'hAA, 1'b0);   // m4, different
      tick();                                          // m3 compared
      tests_run++;
      if (state_o !== 2'b11 || fault_o !== 1'b1) begin
         tests_failed++; $display("FAIL fault_enter: state=%b fault=%b expected 11/1", state_o, fault_o);
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();                                          // m4 compared
      tests_run++;
      if (mismatch_o !== 1'b1 || fault_o !== 1'b1 || err_count_o !== 16'd4) begin
         tests_failed++; $display("FAIL fault_fourth: mis=%b fault=%b err=%0d expected 1/1/4",
                                  mismatch_o, fault_o, err_count_o);
      end
      tests_run++;
      if (first_err_o !== {8'h10, 1'b0, 8'h11, 1'b0} || first_err_sel_o !== 2'b10) begin
         tests_failed++; $display("FAIL fault_capture_kept: fe=%h sel=%b expected %h/10",
                                  first_err_o, first_err_sel_o, {8'h10, 1'b0, 8'h11, 1'b0});
      end
   endtask

   // runs straight after test_fault, so the DUT starts in FAULT with counts
   task automatic test_clear_midstream();
      drive(1'b1, 2'b00, 8'h20, 1'b0, 8'h21, 1'b0);   // mismatch into stage 1
      tick();
      clear_i = 1'b1;
      drive(1'b1, 2'b00, 8'h30, 1'b0, 8'h31, 1'b0);   // ignored by clear
      tick();
      tests_run++;
      if ({mismatch_o, fault_o, state_o, cmp_count_o, err_count_o, first_err_o,
           first_err_sel_o, first_err_vld_o} !== '0) begin
         tests_failed++;
         $display("FAIL clear_outputs: mis=%b flt=%b st=%b cmp=%0d err=%0d fe=%h vld=%b, all must be 0",
                  mismatch_o, fault_o, state_o, cmp_count_o, err_count_o, first_err_o, first_err_vld_o);
      end
      clear_i = 1'b0;
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      tests_run++;
      if (mismatch_o !== 1'b0 || cmp_count_o !== 16'd0 || state_o !== 2'b00) begin
         tests_failed++; $display("FAIL clear_after: mis=%b cmp=%0d state=%b expected 0/0/00",
                                  mismatch_o, cmp_count_o, state_o);
      end
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 2'b00, 8'h40, 1'b1, 8'h40, 1'b1);
      tick();
      drive(1'b1, 2'b00, 8'h40, 1'b1, 8'h41, 1'b1);
      tick();
      wb_rst_i = 1'b1;
      clear_i  = 1'b1;
      drive(1'b1, 2'b00, 8'h50, 1'b0, 8'h51, 1'b0);
      tick();
      wb_rst_i = 1'b0;
      clear_i  = 1'b0;
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      tests_run++;
      if (mismatch_o !== 1'b0 || cmp_count_o !== 16'd0 || err_count_o !== 16'd0
          || state_o !== 2'b00) begin
         tests_failed++; $display("FAIL reset_mid: mis=%b cmp=%0d err=%0d state=%b expected 0/0/0/00",
                                  mismatch_o, cmp_count_o, err_count_o, state_o);
      end
      tick();
      tests_run++;
      if (mismatch_o !== 1'b0 || cmp_count_o !== 16'd0) begin
         tests_failed++; $display("FAIL reset_mid_after: mis=%b cmp=%0d expected 0/0", mismatch_o, cmp_count_o);
      end
   endtask

   task automatic test_saturation_enable();
      int pulses = 0;
      do_clear();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 2'b00, 8'h7F, 1'b0, 8'h7F, 1'b0);
         tick();
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      repeat (2) tick();
      tests_run++;
      if (sat_cmp_count !== 4'd15) begin
         tests_failed++; $display("FAIL sat_cmp: got %0d expected 15", sat_cmp_count);
      end
      tests_run++;
      if (cmp_count_o !== 16'd20) begin
         tests_failed++; $display("FAIL wide_cmp: got %0d expected 20", cmp_count_o);
      end
      enable_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'b00, 8'h01, 1'b0, 8'h02, 1'b0);
         tick();
         if (mismatch_o !== 1'b0) pulses++;
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      repeat (2) begin
         tick();
         if (mismatch_o !== 1'b0) pulses++;
      end
      tests_run++;
      if (pulses != 0 || cmp_count_o !== 16'd20 || sat_cmp_count !== 4'd15
          || err_count_o !== 16'd0 || state_o !== 2'b01) begin
         tests_failed++; $display("FAIL enable_freeze: pulses=%0d cmp=%0d sat=%0d err=%0d state=%b expected 0/20/15/0/01",
                                  pulses, cmp_count_o, sat_cmp_count, err_count_o, state_o);
      end
      // a compare already in stage 1 completes after enable drops
      enable_i = 1'b1;
      drive(1'b1, 2'b00, 8'h01, 1'b0, 8'h02, 1'b0);
      tick();
      enable_i = 1'b0;
      drive(1'b1, 2'b00, 8'h03, 1'b0, 8'h04, 1'b0);
      tick();
      tests_run++;
      if (mismatch_o !== 1'b1 || err_count_o !== 16'd1 || cmp_count_o !== 16'd21
          || sat_cmp_count !== 4'd15 || sat_err_count !== 4'd1 || state_o !== 2'b10) begin
         tests_failed++; $display("FAIL enable_inflight: mis=%b err=%0d cmp=%0d sat_cmp=%0d sat_err=%0d state=%b expected 1/1/21/15/1/10",
                                  mismatch_o, err_count_o, cmp_count_o, sat_cmp_count, sat_err_count, state_o);
      end
      drive(1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      tests_run++;
      if (mismatch_o !== 1'b0 || err_count_o !== 16'd1 || cmp_count_o !== 16'd21) begin
         tests_failed++; $display("FAIL enable_after: mis=%b err=%0d cmp=%0d expected 0/1/21",
                                  mismatch_o, err_count_o, cmp_count_o);
      end
      enable_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_match_stream();
      test_single_glitch();
      test_fault();
      test_clear_midstream();
      test_reset_midstream();
      test_saturation_enable();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_alu_lockstep_checker
